// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the register file's single write port between the in-order pipeline
// writeback (EX/WB register) and a multi-cycle coprocessor result channel.
// The pipeline normally wins the port. A starvation counter forces a one-slot
// bubble (DRAIN then FORCE) so a waiting coprocessor result always lands.
//
// Optional feature macro: WBARB_SCOREBOARD_EN
//   defined   : busy-bit scoreboard and decode hazard_stall are built
//   undefined : no busy storage, hazard_stall tied low, scoreboard inputs ignored
module wb_port_arbiter #(
    parameter int DATA_W       = 8,
    parameter int AW           = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [AW-1:0]     pipe_rd,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              cp_valid,
    input  logic [AW-1:0]     cp_rd,
    input  logic [DATA_W-1:0] cp_data,
    output logic              cp_ready,
    input  logic              cp_issue,
    input  logic [AW-1:0]     cp_issue_rd,
    input  logic [AW-1:0]     id_rs1,
    input  logic [AW-1:0]     id_rs2,
    input  logic              id_we,
    input  logic [AW-1:0]     id_rd,
    output logic              hazard_stall,
    output logic              stall_pipe,
    output logic              rf_we,
    output logic [AW-1:0]     rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    // Counter is 4 bits wide so any limit in 1..15 fits.
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    state_t       state_r;
    state_t       state_s;
    logic [3:0]   starve_cnt_r;
    logic [3:0]   starve_cnt_s;
    logic         grant_pipe_s;
    logic         grant_cp_s;
    logic         stall_pipe_r;

    // Next-state, starvation counting and grant selection.
    always_comb begin
        state_s      = state_r;
        starve_cnt_s = starve_cnt_r;
        grant_pipe_s = 1'b0;
        grant_cp_s   = 1'b0;
        case (state_r)
            ST_ARB: begin
                if (pipe_we) begin
                    grant_pipe_s = 1'b1;
                end else if (cp_valid) begin
                    grant_cp_s = 1'b1;
                end else begin
                    grant_pipe_s = 1'b0;
                end
                // Only a cycle where both sources want the port counts as blocked.
                if (pipe_we && cp_valid) begin
                    if ((starve_cnt_r + 4'd1) == LIMIT_C) begin
                        starve_cnt_s = 4'd0;
                        state_s      = ST_DRAIN;
                    end else begin
                        starve_cnt_s = starve_cnt_r + 4'd1;
                    end
                end else begin
                    starve_cnt_s = 4'd0;
                end
            end
            ST_DRAIN: begin
                // The result already in EX/WB still gets its slot; the bubble
                // requested by stall_pipe arrives one cycle later (FORCE).
                starve_cnt_s = 4'd0;
                if (pipe_we) begin
                    grant_pipe_s = 1'b1;
                    state_s      = ST_FORCE;
                end else begin
                    grant_cp_s = cp_valid;
                    state_s    = ST_ARB;
                end
            end
            ST_FORCE: begin
                // Coprocessor owns the slot; a pipeline write here is dropped.
                starve_cnt_s = 4'd0;
                grant_cp_s   = cp_valid;
                state_s      = ST_ARB;
            end
            default: begin
                starve_cnt_s = 4'd0;
                state_s      = ST_ARB;
            end
        endcase
    end

    // Arbiter state, starvation counter and registered bubble request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_ARB;
            starve_cnt_r <= 4'd0;
            stall_pipe_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            starve_cnt_r <= starve_cnt_s;
            stall_pipe_r <= (state_s != ST_ARB);
        end
    end

    // Registered write port: granted source is written, otherwise address/data hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (grant_pipe_s) begin
            rf_we    <= 1'b1;
            rf_waddr <= pipe_rd;
            rf_wdata <= pipe_data;
        end else if (grant_cp_s) begin
            rf_we    <= 1'b1;
            rf_waddr <= cp_rd;
            rf_wdata <= cp_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    assign cp_ready   = reset & grant_cp_s;
    assign stall_pipe = stall_pipe_r;

`ifdef WBARB_SCOREBOARD_EN
    logic [2**AW-1:0] busy_r;
    logic [2**AW-1:0] busy_s;

    // Busy vector update: clear on coprocessor grant, issue applied last so it wins.
    always_comb begin
        busy_s = busy_r;
        if (grant_cp_s) begin
            busy_s[cp_rd] = 1'b0;
        end else begin
            busy_s[cp_rd] = busy_r[cp_rd];
        end
        if (cp_issue) begin
            busy_s[cp_issue_rd] = 1'b1;
        end else begin
            busy_s[cp_issue_rd] = busy_s[cp_issue_rd];
        end
    end

    // Busy vector storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_s;
        end
    end

    assign hazard_stall = reset & (busy_r[id_rs1] | busy_r[id_rs2] | (id_we & busy_r[id_rd]));
`else
    // Scoreboard inputs stay on the port list but have no function in this build.
    logic unused_sb_s;
    assign unused_sb_s  = ^{cp_issue, cp_issue_rd, id_rs1, id_rs2, id_we, id_rd};
    assign hazard_stall = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, hand-written
// starvation / scoreboard / reset sequences, and randomized traffic compared
// against a cycle-level behavioural model of the arbitration rules.
module tb_wb_port_arbiter;

    localparam int DW  = 8;
    localparam int AW  = 3;
    localparam int LIM = 4;
    localparam int NR  = 8;
`ifdef WBARB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          pipe_we;
    logic [AW-1:0] pipe_rd;
    logic [DW-1:0] pipe_data;
    logic          cp_valid;
    logic [AW-1:0] cp_rd;
    logic [DW-1:0] cp_data;
    logic          cp_ready;
    logic          cp_issue;
    logic [AW-1:0] cp_issue_rd;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic          id_we;
    logic [AW-1:0] id_rd;
    logic          hazard_stall;
    logic          stall_pipe;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    wb_port_arbiter #(.DATA_W(DW), .AW(AW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .cp_valid(cp_valid), .cp_rd(cp_rd), .cp_data(cp_data), .cp_ready(cp_ready),
        .cp_issue(cp_issue), .cp_issue_rd(cp_issue_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_we(id_we), .id_rd(id_rd),
        .hazard_stall(hazard_stall), .stall_pipe(stall_pipe),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 normal arbitration, 1 slot after starvation, 2 reserved coprocessor slot
    int            m_phase;
    int            m_blk;
    bit            m_busy [NR];
    bit            m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    bit            m_cp_granted;
    int            cp_wait;

    task automatic model_reset();
        m_phase = 0;
        m_blk   = 0;
        for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_cp_granted = 1'b0;
        cp_wait = 0;
    endtask

    // One clock cycle: inputs are already driven (just after a falling edge).
    task automatic cycle(input string tag);
        int grant;
        int nphase;
        bit hz;
        #1;
        grant  = 0;
        nphase = 0;
        case (m_phase)
            0: begin
                if (pipe_we) grant = 1;
                else if (cp_valid) grant = 2;
                if (pipe_we && cp_valid) begin
                    m_blk = m_blk + 1;
                    if (m_blk == LIM) begin
                        m_blk  = 0;
                        nphase = 1;
                    end
                end else begin
                    m_blk = 0;
                end
            end
            1: begin
                m_blk = 0;
                if (pipe_we) begin
                    grant  = 1;
                    nphase = 2;
                end else if (cp_valid) begin
                    grant = 2;
                end
            end
            default: begin
                m_blk = 0;
                if (cp_valid) grant = 2;
            end
        endcase
        hz = SB_EN && (m_busy[id_rs1] || m_busy[id_rs2] || (id_we && m_busy[id_rd]));
        chk({tag, ".cp_ready"}, cp_ready, (grant == 2));
        chk({tag, ".hazard"}, hazard_stall, hz);
        chk({tag, ".stall_pipe"}, stall_pipe, (m_phase != 0));
        if (cp_valid && grant != 2) cp_wait++;
        if (grant == 2) chk({tag, ".cp_wait_bound"}, (cp_wait <= LIM + 2), 1);
        if (grant == 2) m_busy[cp_rd] = 1'b0;
        if (cp_issue) m_busy[cp_issue_rd] = 1'b1;
        if (grant == 1) begin
            m_we = 1'b1; m_waddr = pipe_rd; m_wdata = pipe_data;
        end else if (grant == 2) begin
            m_we = 1'b1; m_waddr = cp_rd; m_wdata = cp_data;
        end else begin
            m_we = 1'b0;
        end
        m_cp_granted = (grant == 2);
        m_phase = nphase;
        @(posedge clk);
        #1;
        chk({tag, ".rf_we"}, rf_we, m_we);
        chk({tag, ".rf_waddr"}, rf_waddr, m_waddr);
        chk({tag, ".rf_wdata"}, rf_wdata, m_wdata);
        @(negedge clk);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic          pwe;
        logic [AW-1:0] prd;
        logic [DW-1:0] pdat;
        logic          cv;
        logic [AW-1:0] crd;
        logic [DW-1:0] cdat;
        logic          ready;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd3, 8'h5A}; // pipeline only
        tbl[1] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'hC3, 1'b1, 1'b1, 3'd6, 8'hC3}; // idle-slot grant
        tbl[2] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd6, 8'hC3}; // no grant, hold
        tbl[3] = '{1'b1, 3'd7, 8'h11, 1'b1, 3'd2, 8'h99, 1'b0, 1'b1, 3'd7, 8'h11}; // both, pipe wins
        tbl[4] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h99, 1'b1, 1'b1, 3'd2, 8'h99}; // held cp lands
        tbl[5] = '{1'b0, 3'd1, 8'hFF, 1'b0, 3'd5, 8'h42, 1'b0, 1'b0, 3'd2, 8'h99}; // hold again

        reset = 1'b0;
        pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
        cp_valid = 1'b1; cp_rd = 3'd1; cp_data = 8'hAA;
        cp_issue = 1'b0; cp_issue_rd = '0;
        id_rs1 = '0; id_rs2 = '0; id_we = 1'b0; id_rd = '0;
        model_reset();

        // Reset values (cp_valid high to show cp_ready is masked).
        #12;
        chk("rst.rf_we", rf_we, 0);
        chk("rst.rf_waddr", rf_waddr, 0);
        chk("rst.rf_wdata", rf_wdata, 0);
        chk("rst.stall_pipe", stall_pipe, 0);
        chk("rst.cp_ready", cp_ready, 0);
        chk("rst.hazard", hazard_stall, 0);
        @(negedge clk);
        reset = 1'b1;
        cp_valid = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 6; i++) begin
            pipe_we = tbl[i].pwe; pipe_rd = tbl[i].prd; pipe_data = tbl[i].pdat;
            cp_valid = tbl[i].cv; cp_rd = tbl[i].crd; cp_data = tbl[i].cdat;
            #1;
            chk($sformatf("tbl%0d.cp_ready", i), cp_ready, tbl[i].ready);
            cycle($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.we", i), rf_we, tbl[i].we);
            chk($sformatf("tbl%0d.waddr", i), rf_waddr, tbl[i].wa);
            chk($sformatf("tbl%0d.wdata", i), rf_wdata, tbl[i].wd);
        end

        // Starvation: four blocked cycles, DRAIN, FORCE, back to ARB.
        pipe_we = 1'b1; cp_valid = 1'b1; cp_rd = 3'd4; cp_data = 8'hE7;
        for (int i = 0; i < 4; i++) begin
            pipe_rd = 3'(i); pipe_data = 8'(8'h10 + i);
            #1;
            chk("starve.blocked_ready", cp_ready, 0);
            chk("starve.blocked_stall", stall_pipe, 0);
            cycle("starve");
        end
        pipe_rd = 3'd1; pipe_data = 8'h44;
        #1;
        chk("starve.drain_stall", stall_pipe, 1);
        chk("starve.drain_ready", cp_ready, 0);
        cycle("drain");
        chk("starve.drain_we", rf_we, 1);
        chk("starve.drain_data", rf_wdata, 8'h44);
        pipe_we = 1'b0;
        #1;
        chk("starve.force_stall", stall_pipe, 1);
        chk("starve.force_ready", cp_ready, 1);
        cycle("force");
        chk("starve.cp_we", rf_we, 1);
        chk("starve.cp_waddr", rf_waddr, 3'd4);
        chk("starve.cp_wdata", rf_wdata, 8'hE7);
        cp_valid = 1'b0;
        #1;
        chk("starve.back_arb", stall_pipe, 0);
        cycle("starve_idle");

        // Scoreboard: issue to r2, hazard until the edge after the r2 grant.
        cp_issue = 1'b1; cp_issue_rd = 3'd2;
        cycle("sb_issue");
        cp_issue = 1'b0; id_rs1 = 3'd2;
        #1;
        chk("sb.hazard_set", hazard_stall, SB_EN);
        cycle("sb_wait");
        cp_valid = 1'b1; cp_rd = 3'd2; cp_data = 8'h77;
        #1;
        chk("sb.hazard_grant_cycle", hazard_stall, SB_EN);
        cycle("sb_grant");
        cp_valid = 1'b0;
        #1;
        chk("sb.hazard_cleared", hazard_stall, 0);
        cycle("sb_clear");
        // Re-issue on the grant edge keeps the bit set.
        cp_issue = 1'b1; cp_issue_rd = 3'd2;
        cycle("sb_reissue0");
        cp_valid = 1'b1; cp_rd = 3'd2; cp_data = 8'h78;
        cycle("sb_reissue1");
        cp_issue = 1'b0; cp_valid = 1'b0;
        id_rs1 = 3'd0; id_rs2 = 3'd0; id_we = 1'b1; id_rd = 3'd2;
        #1;
        chk("sb.waw_after_reissue", hazard_stall, SB_EN);
        cycle("sb_waw");
        cp_valid = 1'b1; cp_rd = 3'd2; cp_data = 8'h79;
        cycle("sb_final_grant");
        cp_valid = 1'b0; id_we = 1'b0;
        cycle("sb_done");

        // Reset mid-FORCE with busy[5] set.
        cp_issue = 1'b1; cp_issue_rd = 3'd5;
        cycle("rf_issue");
        cp_issue = 1'b0;
        pipe_we = 1'b1; cp_valid = 1'b1; cp_rd = 3'd6; cp_data = 8'hBD;
        for (int i = 0; i < 5; i++) begin
            pipe_rd = 3'd3; pipe_data = 8'(8'h20 + i);
            cycle("rf_pre");
        end
        pipe_we = 1'b0; id_rs1 = 3'd5;
        #1;
        chk("rf.in_force", stall_pipe, 1);
        reset = 1'b0;
        #1;
        chk("rf.rst_we", rf_we, 0);
        chk("rf.rst_waddr", rf_waddr, 0);
        chk("rf.rst_wdata", rf_wdata, 0);
        chk("rf.rst_stall", stall_pipe, 0);
        chk("rf.rst_ready", cp_ready, 0);
        chk("rf.rst_hazard", hazard_stall, 0);
        model_reset();
        @(posedge clk);
        #1;
        chk("rf.no_cp_write", rf_we, 0);
        @(negedge clk);
        reset = 1'b1; cp_valid = 1'b0;
        cycle("rf_after");

        // Randomized traffic against the model.
        id_rs1 = '0; id_rs2 = '0; id_we = 1'b0; id_rd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!(cp_valid && !m_cp_granted)) begin
                cp_valid = ($urandom_range(0, 2) != 0);
                cp_rd    = 3'($urandom);
                cp_data  = 8'($urandom);
                cp_wait  = 0;
            end
            pipe_we     = (m_phase == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            pipe_rd     = 3'($urandom);
            pipe_data   = 8'($urandom);
            cp_issue    = ($urandom_range(0, 3) == 0);
            cp_issue_rd = 3'($urandom);
            id_rs1      = 3'($urandom);
            id_rs2      = 3'($urandom);
            id_we       = 1'($urandom);
            id_rd       = 3'($urandom);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Write-port arbiter and scoreboard for the register file's single write port in the 4-stage pipeline. It shares the port between the in-order pipeline result leaving the EX/WB register and a multi-cycle coprocessor with a valid/ready handshake. The pipeline has priority, and a starvation counter forces a one-slot bubble so the coprocessor always completes. A busy-bit scoreboard raises a decode hazard while a coprocessor result is outstanding.

## Interface
Parameters:
- DATA_W, 8, data width
- AW, 3, register address width (2**AW registers)
- STARVE_LIMIT, 4, consecutive blocked cycles before a forced slot; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- pipe_we  in  1  pipeline writeback valid, from the EX/WB register
- pipe_rd  in  AW  pipeline destination
- pipe_data  in  DATA_W  pipeline result
- cp_valid  in  1  coprocessor result valid
- cp_rd  in  AW  coprocessor destination
- cp_data  in  DATA_W  coprocessor result
- cp_ready  out  1  coprocessor result accepted this cycle (combinational)
- cp_issue  in  1  decode issues a coprocessor op this cycle
- cp_issue_rd  in  AW  destination of the issued op
- id_rs1, id_rs2  in  AW  decode source registers
- id_we, id_rd  in  1/AW  decode write enable and destination
- hazard_stall  out  1  decode must hold (combinational)
- stall_pipe  out  1  upstream must insert a bubble into EX/WB
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  AW  write address (registered)
- rf_wdata  out  DATA_W  write data (registered)

## Operation
- FSM states are ARB, DRAIN and FORCE. Reset state is ARB.
- ARB:
  - If pipe_we is 1, the pipeline is granted.
  - Otherwise, if cp_valid is 1, the coprocessor is granted and cp_ready is 1.
  - A blocked cycle is one where cp_valid=1 and pipe_we=1. Each blocked cycle increments starve_cnt.
  - When the increment would make starve_cnt equal STARVE_LIMIT, starve_cnt clears and the next state is DRAIN.
  - starve_cnt clears on any coprocessor grant and on any cycle with cp_valid=0.
- DRAIN:
  - stall_pipe=1.
  - If pipe_we=1, the pipeline is granted and the next state is FORCE.
  - If pipe_we=0, the coprocessor is granted and the next state is ARB.
- FORCE:
  - stall_pipe=1.
  - Upstream contract: pipe_we=0 in this state.
  - The coprocessor is granted unconditionally and the next state is ARB.
  - If pipe_we=1 anyway, the coprocessor still wins and the pipeline write is dropped. Verification flags this as a protocol error.
- Handshake: once cp_valid is asserted, cp_valid, cp_rd and cp_data hold stable until the cycle with cp_ready=1.
- Granted write: on the clock edge, rf_we=1 and rf_waddr/rf_wdata take the granted source's values. With no grant, rf_we=0 and the address and data hold their values.
- Scoreboard busy[2**AW-1:0]:
  - Sets busy[cp_issue_rd] on cp_issue.
  - Clears busy[cp_rd] on the coprocessor grant edge.
  - If set and clear hit the same index on the same edge, set wins.
- hazard_stall = busy[id_rs1] | busy[id_rs2] | (id_we & busy[id_rd]). The WAW term is included.
- All registers are treated identically; no register is hardwired.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, stall_pipe=0, busy=0, starve_cnt=0, state=ARB.
- While reset is low, cp_ready=0 and hazard_stall=0.
- Reset applied mid-operation (in DRAIN or FORCE, or with busy bits set) clears everything immediately. A pending coprocessor result is not written.
- Write latency is 1 cycle: a grant in cycle N gives rf_we=1 in cycle N+1.
- cp_ready and hazard_stall are combinational from the current state and inputs.
- stall_pipe is a decode of the registered state, so it has no combinational path from inputs.
- Worst-case coprocessor wait from cp_valid rising is STARVE_LIMIT+2 cycles.
- If reset releases coincident with a clock edge, the first active edge is the following one.

## Configuration
- Macro WBARB_SCOREBOARD_EN.
- Defined: the busy vector and hazard_stall logic are compiled in, as specified above.
- Undefined: no busy storage is built and hazard_stall is tied 0. Decode then relies on software scheduling. The cp_issue, cp_issue_rd, id_* ports remain present and are ignored.

## Test plan
- Pipeline-only traffic: pipe_we=1, pipe_rd=3, pipe_data=0x5A in cycle 0 -> rf_we=1, rf_waddr=3, rf_wdata=0x5A in cycle 1; cp_ready=0.
- Idle-slot grant: pipe_we=0, cp_valid=1, cp_rd=6, cp_data=0xC3 -> cp_ready=1 the same cycle; the next cycle gives rf_waddr=6, rf_wdata=0xC3; starve_cnt=0.
- Starvation with STARVE_LIMIT=4: pipe_we=1 continuously and cp_valid=1 from cycle 0 ->
  - cycles 0-3 are blocked;
  - cycle 4 is DRAIN: stall_pipe=1 and the pipeline is granted;
  - in cycle 5 the bench drives pipe_we=0: FORCE, cp_ready=1;
  - cycle 6 shows rf_we=1 with the coprocessor data, and state is back to ARB.
- Scoreboard (macro defined): cp_issue with cp_issue_rd=2, then id_rs1=2 -> hazard_stall=1 until the edge after the cp_rd=2 grant. A simultaneous re-issue to 2 on the grant edge keeps busy[2]=1.
- Reset mid-FORCE: assert reset low in FORCE with busy[5]=1 -> all outputs go to their reset values immediately and no coprocessor write occurs. After release, the state is ARB.
- Macro undefined: repeat the scoreboard stimulus -> hazard_stall stays 0.
